// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : riscv_pkg
// Purpose : Shared RV32 decode definitions for the decode stage: data width,
//           opcode constants, ALUControl / ResultSrc / ImmSrc encodings, the
//           decoded-control and E-register structs, and small decode helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // Major opcodes understood by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // Decoded control; all-zero is the NOP encoding
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    alu_ctrl_e   alu_control;
    logic        alu_src;
    imm_src_e    imm_src;
    logic        branch_eq;
    logic        branch_ne;
    logic        jal;
    logic        jalr;
    logic        lui;
  } ctrl_t;

  // Contents of the D->E pipeline register
  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_reg_t;

  // Unsupported funct3 values fall back to add rather than trapping
  function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr, input imm_src_e src);
    case (src)
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   return {instr[31:12], 12'h000};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface : decode_stage_if
// Purpose   : Bundles the decode-stage bus: fetch inputs, writeback port,
//             flush, D-stage redirect outputs and the E-register outputs.
// Modports  : slave  - the decode stage (consumes D/W inputs, drives E/D outs)
//             master - the surrounding pipeline / testbench
// Rev       : 1.0  initial release
// ============================================================================
interface decode_stage_if;
  import riscv_pkg::*;

  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;

  logic            PCSrcD;
  logic            JalD;
  logic [XLEN-1:0] PCTargetD;

  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic [2:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output PCSrcD, JalD, PCTargetD,
    output RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  PCSrcD, JalD, PCTargetD,
    input  RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );

endinterface
`default_nettype wire

// File: rtl/register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : register_file
// Purpose : 32 x XLEN architectural register file, x0 hard-wired to zero.
//           Two combinational read ports with write-through bypass, one
//           write port committed on the rising edge, asynchronous reset.
// Ports   : clk, rst        - clock, async active-high reset
//           ra1_i / ra2_i   - read addresses;  rd1_o / rd2_o - read data
//           we_i, wa_i, wd_i - write enable, address, data
// Rev     : 1.0  initial release
// ============================================================================
module register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] regs_q [32];
  logic            wr_live;

  // A write aimed at x0, or one coinciding with reset, is never visible
  assign wr_live = we_i && (wa_i != 5'd0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0)              ? '0   :
                 (wr_live && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0)              ? '0   :
                 (wr_live && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : decode_stage
// Purpose : RV32 instruction decode: control decode, immediate generation,
//           register read (via register_file), branch comparison, redirect
//           target generation and the D->E pipeline register with flush.
// Ports   : clk, rst - clock, async active-high reset
//           bus      - decode_stage_if.slave: InstrD/PCD/PCPlus4D from fetch,
//                      RegWriteW/RdW/ResultW from writeback, FlushE,
//                      PCSrcD/JalD/PCTargetD redirect, all *E register fields
// Rev     : 1.0  initial release
// ============================================================================
module decode_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  ctrl_t           ctrl;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] jalr_sum;
  ex_reg_t         ereg_d;
  ex_reg_t         ereg_q;

  assign opcode   = bus.InstrD[6:0];
  assign funct3   = bus.InstrD[14:12];
  assign funct7_5 = bus.InstrD[30];

  register_file u_register_file (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (bus.InstrD[19:15]),
    .ra2_i (bus.InstrD[24:20]),
    .we_i  (bus.RegWriteW),
    .wa_i  (bus.RdW),
    .wd_i  (bus.ResultW),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  // Control decode; anything unrecognised stays at the all-zero NOP
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_decode(funct3, funct7_5);
      end
      OP_I_ALU: begin
        // funct7[5] is immediate data here, so it never selects sub
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_decode(funct3, 1'b0);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.imm_src   = IMM_B;
        ctrl.branch_eq = (funct3 == 3'b000);
        ctrl.branch_ne = (funct3 == 3'b001);
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.imm_src    = IMM_J;
        ctrl.jal        = 1'b1;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src    = 1'b1;
        ctrl.jalr       = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.lui       = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_ext  = imm_extend(bus.InstrD, ctrl.imm_src);
  assign jalr_sum = rd1 + imm_ext;

  // Branch resolution and redirect use the bypassed read data
  assign bus.PCSrcD    = (ctrl.branch_eq && (rd1 == rd2)) || (ctrl.branch_ne && (rd1 != rd2));
  assign bus.JalD      = ctrl.jal || ctrl.jalr;
  assign bus.PCTargetD = ctrl.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.PCD + imm_ext);

  // A flush loads a full bubble, data fields included
  always_comb begin
    ereg_d = '0;
    if (!bus.FlushE) begin
      ereg_d.reg_write   = ctrl.reg_write;
      ereg_d.result_src  = ctrl.result_src;
      ereg_d.mem_write   = ctrl.mem_write;
      ereg_d.alu_control = ctrl.alu_control;
      ereg_d.alu_src     = ctrl.alu_src;
      // lui reuses the ALU add path: 0 + immediate
      ereg_d.rd1         = ctrl.lui ? '0 : rd1;
      ereg_d.rd2         = rd2;
      ereg_d.imm_ext     = imm_ext;
      ereg_d.pc          = bus.PCD;
      ereg_d.pc_plus4    = bus.PCPlus4D;
      ereg_d.rs1         = bus.InstrD[19:15];
      ereg_d.rs2         = bus.InstrD[24:20];
      ereg_d.rd          = bus.InstrD[11:7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ereg_q <= '0;
    end else begin
      ereg_q <= ereg_d;
    end
  end

  assign bus.RegWriteE   = ereg_q.reg_write;
  assign bus.ResultSrcE  = ereg_q.result_src;
  assign bus.MemWriteE   = ereg_q.mem_write;
  assign bus.ALUControlE = ereg_q.alu_control;
  assign bus.ALUSrcE     = ereg_q.alu_src;
  assign bus.RD1E        = ereg_q.rd1;
  assign bus.RD2E        = ereg_q.rd2;
  assign bus.ImmExtE     = ereg_q.imm_ext;
  assign bus.PCE         = ereg_q.pc;
  assign bus.PCPlus4E    = ereg_q.pc_plus4;
  assign bus.Rs1E        = ereg_q.rs1;
  assign bus.Rs2E        = ereg_q.rs2;
  assign bus.RdE         = ereg_q.rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_decode_stage
// Purpose : Self-checking bench for decode_stage. Instructions are built from
//           chosen fields and immediates; the expected E-register contents
//           are pushed to a scoreboard queue and compared by a monitor after
//           each rising edge. Redirect outputs are checked in the D cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_decode_stage;
  import riscv_pkg::*;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_JAL = 6, K_JALR = 7, K_LUI = 8, K_BAD = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  alu;
    logic        asrc;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  s1, s2, d;
    bit          imm_chk;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] m_regs [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural read as seen in D: x0 is zero, a live write is visible at once
  function automatic logic [31:0] rv(input logic [4:0] a, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  // Instruction encoders: fields in, instruction word out
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction
  function automatic logic [31:0] i_ins(input int v, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] x;
    x = v;
    return {x[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_ins(input int v, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] x;
    x = v;
    return {x[11:5], rs2, rs1, 3'b010, x[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] b_ins(input int v, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    logic [31:0] x;
    x = v;
    return {x[12], x[10:5], rs2, rs1, f3, x[4:1], x[11], OP_BRANCH};
  endfunction
  function automatic logic [31:0] j_ins(input int v, input logic [4:0] rd);
    logic [31:0] x;
    x = v;
    return {x[20], x[10:1], x[11], x[19:12], rd, OP_JAL};
  endfunction

  // One D cycle: drive, check redirect outputs, queue expected E, commit model write
  task automatic step(input logic [31:0] ins, input int kind, input logic [31:0] imm,
                      input logic [2:0] alu, input logic [31:0] pc, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    exp_t        e;
    logic [31:0] a, b;
    logic        take;
    @(negedge clk);
    bus.InstrD = ins; bus.PCD = pc; bus.PCPlus4D = pc + 32'd4;
    bus.RegWriteW = we; bus.RdW = wa; bus.ResultW = wd; bus.FlushE = fl;
    #2;
    a    = rv(ins[19:15], we, wa, wd);
    b    = rv(ins[24:20], we, wa, wd);
    take = (kind == K_BEQ && a == b) || (kind == K_BNE && a != b);
    chk("PCSrcD", {31'd0, bus.PCSrcD}, {31'd0, take});
    chk("JalD", {31'd0, bus.JalD}, {31'd0, (kind == K_JAL || kind == K_JALR)});
    if (kind == K_JALR)
      chk("PCTargetD_jalr", bus.PCTargetD, (a + imm) & ~32'd1);
    else if (kind == K_BEQ || kind == K_BNE || kind == K_JAL)
      chk("PCTargetD", bus.PCTargetD, pc + imm);
    e = '{rw: 1'b0, rs: 2'b00, mw: 1'b0, alu: 3'b000, asrc: 1'b0, rd1: 32'h0, rd2: 32'h0,
          imm: 32'h0, pc: 32'h0, pc4: 32'h0, s1: 5'd0, s2: 5'd0, d: 5'd0, imm_chk: 1'b1};
    if (!fl) begin
      e.rw   = (kind == K_R || kind == K_I || kind == K_LW || kind == K_JAL ||
                kind == K_JALR || kind == K_LUI);
      e.rs   = (kind == K_LW) ? 2'b01 : (kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00;
      e.mw   = (kind == K_SW);
      e.alu  = alu;
      e.asrc = (kind == K_I || kind == K_LW || kind == K_SW || kind == K_JALR || kind == K_LUI);
      e.rd1  = (kind == K_LUI) ? 32'h0 : a;
      e.rd2  = b;
      e.imm  = imm;
      e.imm_chk = !(kind == K_R || kind == K_BAD);
      e.pc   = pc;
      e.pc4  = pc + 32'd4;
      e.s1   = ins[19:15];
      e.s2   = ins[24:20];
      e.d    = ins[11:7];
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (we && wa != 5'd0) m_regs[wa] = wd;
  endtask

  // Monitor: every edge that follows a queued D cycle presents one E result
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("RegWriteE",   {31'd0, bus.RegWriteE},   {31'd0, mon_e.rw});
      chk("ResultSrcE",  {30'd0, bus.ResultSrcE},  {30'd0, mon_e.rs});
      chk("MemWriteE",   {31'd0, bus.MemWriteE},   {31'd0, mon_e.mw});
      chk("ALUControlE", {29'd0, bus.ALUControlE}, {29'd0, mon_e.alu});
      chk("ALUSrcE",     {31'd0, bus.ALUSrcE},     {31'd0, mon_e.asrc});
      chk("RD1E", bus.RD1E, mon_e.rd1);
      chk("RD2E", bus.RD2E, mon_e.rd2);
      if (mon_e.imm_chk) chk("ImmExtE", bus.ImmExtE, mon_e.imm);
      chk("PCE", bus.PCE, mon_e.pc);
      chk("PCPlus4E", bus.PCPlus4E, mon_e.pc4);
      chk("Rs1E", {27'd0, bus.Rs1E}, {27'd0, mon_e.s1});
      chk("Rs2E", {27'd0, bus.Rs2E}, {27'd0, mon_e.s2});
      chk("RdE",  {27'd0, bus.RdE},  {27'd0, mon_e.d});
    end
  end

  task automatic check_e_zero(input string tag);
    chk({tag, "_RegWriteE"}, {31'd0, bus.RegWriteE}, 32'h0);
    chk({tag, "_ResultSrcE"}, {30'd0, bus.ResultSrcE}, 32'h0);
    chk({tag, "_MemWriteE"}, {31'd0, bus.MemWriteE}, 32'h0);
    chk({tag, "_ALUControlE"}, {29'd0, bus.ALUControlE}, 32'h0);
    chk({tag, "_RD1E"}, bus.RD1E, 32'h0);
    chk({tag, "_ImmExtE"}, bus.ImmExtE, 32'h0);
    chk({tag, "_PCE"}, bus.PCE, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] NOP_W = 32'h0000_0013;  // addi x0,x0,0

  initial begin
    int          kind, v, sel;
    logic [31:0] ins, imm, pc, wd, r;
    logic [2:0]  alu, f3;
    logic [6:0]  f7, op;
    logic [4:0]  rd, rs1, rs2, wa;
    logic        we, fl;

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    rst = 1'b1;
    bus.InstrD = 32'h0; bus.PCD = 32'h0; bus.PCPlus4D = 32'h0; bus.RegWriteW = 1'b0;
    bus.RdW = 5'd0; bus.ResultW = 32'h0; bus.FlushE = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_e_zero("reset");
    rst = 1'b0;

    // x5 reads zero after reset
    step(r_ins(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), K_R, 32'h0, 3'b000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    // write x5 = 0xAA, then add x6,x5,x5
    step(NOP_W, K_I, 32'h0, 3'b000, 32'h4, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
    step(r_ins(7'h00, 5'd5, 5'd5, 3'b000, 5'd6), K_R, 32'h0, 3'b000, 32'h8, 1'b0, 5'd0, 32'h0, 1'b0);
    // bypass: addi x8,x7,-1 while x7 <= 0x1234
    step(i_ins(-1, 5'd7, 3'b000, 5'd8, OP_I_ALU), K_I, 32'hFFFF_FFFF, 3'b000, 32'hC,
         1'b1, 5'd7, 32'h0000_1234, 1'b0);
    // branches with x1 = x2 = 3
    step(NOP_W, K_I, 32'h0, 3'b000, 32'h10, 1'b1, 5'd1, 32'd3, 1'b0);
    step(NOP_W, K_I, 32'h0, 3'b000, 32'h14, 1'b1, 5'd2, 32'd3, 1'b0);
    step(b_ins(16, 5'd2, 5'd1, 3'b000), K_BEQ, 32'd16, 3'b000, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0);
    step(b_ins(16, 5'd2, 5'd1, 3'b001), K_BNE, 32'd16, 3'b000, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0);
    // jal -8 at 0x100, jalr with x1 = 0x201
    step(j_ins(-8, 5'd1), K_JAL, 32'hFFFF_FFF8, 3'b000, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0);
    step(NOP_W, K_I, 32'h0, 3'b000, 32'h104, 1'b1, 5'd1, 32'h201, 1'b0);
    step(i_ins(0, 5'd1, 3'b000, 5'd3, OP_JALR), K_JALR, 32'h0, 3'b000, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
    // flushed store, flush with a same-cycle write, x0 write ignored
    step(s_ins(4, 5'd2, 5'd1), K_SW, 32'd4, 3'b000, 32'h10C, 1'b1, 5'd12, 32'h55, 1'b1);
    step(NOP_W, K_I, 32'h0, 3'b000, 32'h110, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0);
    step(r_ins(7'h00, 5'd12, 5'd0, 3'b000, 5'd9), K_R, 32'h0, 3'b000, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
    // lui places the upper immediate and zeroes RD1E
    step({20'hABCDE, 5'd4, OP_LUI}, K_LUI, 32'hABCD_E000, 3'b000, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);

    // Asynchronous reset mid-cycle discards the pending write and clears E at once
    step(i_ins(5, 5'd5, 3'b000, 5'd4, OP_I_ALU), K_I, 32'd5, 3'b000, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.RdW = 5'd10; bus.ResultW = 32'h0000_DEAD;
    #2;
    rst = 1'b1;
    #1;
    check_e_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    bus.RegWriteW = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    step(r_ins(7'h00, 5'd5, 5'd10, 3'b000, 5'd11), K_R, 32'h0, 3'b000, 32'h204, 1'b0, 5'd0, 32'h0, 1'b0);

    // Randomized traffic over a small register window so equalities and bypasses occur
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      alu  = 3'b000;
      imm  = 32'h0;
      case (kind)
        K_R: begin
          sel = $urandom_range(0, 4);
          f7  = (sel == 1) ? 7'h20 : 7'h00;
          f3  = (sel == 2) ? 3'b111 : (sel == 3) ? 3'b110 : (sel == 4) ? 3'b010 : 3'b000;
          alu = (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 : (sel == 3) ? 3'b011 :
                (sel == 4) ? 3'b101 : 3'b000;
          ins = r_ins(f7, rs2, rs1, f3, rd);
        end
        K_I: begin
          sel = $urandom_range(0, 3);
          f3  = (sel == 1) ? 3'b111 : (sel == 2) ? 3'b110 : (sel == 3) ? 3'b010 : 3'b000;
          alu = (sel == 1) ? 3'b010 : (sel == 2) ? 3'b011 : (sel == 3) ? 3'b101 : 3'b000;
          v   = int'($urandom_range(0, 4095)) - 2048;
          imm = v;
          ins = i_ins(v, rs1, f3, rd, OP_I_ALU);
        end
        K_LW, K_JALR: begin
          v   = int'($urandom_range(0, 4095)) - 2048;
          imm = v;
          ins = (kind == K_LW) ? i_ins(v, rs1, 3'b010, rd, OP_LOAD)
                               : i_ins(v, rs1, 3'b000, rd, OP_JALR);
        end
        K_SW: begin
          v   = int'($urandom_range(0, 4095)) - 2048;
          imm = v;
          ins = s_ins(v, rs2, rs1);
        end
        K_BEQ, K_BNE: begin
          v   = (int'($urandom_range(0, 8191)) - 4096) & ~1;
          imm = v;
          ins = b_ins(v, rs2, rs1, (kind == K_BEQ) ? 3'b000 : 3'b001);
        end
        K_JAL: begin
          v   = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
          imm = v;
          ins = j_ins(v, rd);
        end
        K_LUI: begin
          r   = $urandom;
          imm = r << 12;
          ins = {r[19:0], rd, OP_LUI};
        end
        default: begin
          op = 7'($urandom);
          while (op == OP_R || op == OP_I_ALU || op == OP_LOAD || op == OP_STORE ||
                 op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI)
            op = 7'($urandom);
          r   = $urandom;
          ins = {r[31:7], op};
        end
      endcase
      pc = $urandom & ~32'd3;
      we = ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(0, 7));
      wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      fl = ($urandom_range(0, 9) == 0);
      step(ins, kind, imm, alu, pc, we, wa, wd, fl);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
